// File: rtl/frame_reader_pkg.sv
// Shared VGA geometry, pixel type and frame-reader FSM/pipe types.
package frame_reader_pkg;

    localparam int unsigned VGA_H_ACTIVE       = 640;
    localparam int unsigned VGA_V_ACTIVE       = 480;
    localparam int unsigned VGA_WORDS_PER_LINE = 320;

    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned COORD_W = 11;
    localparam int unsigned WORD_W  = 24;
    localparam int unsigned PIX_W   = 12;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        RUN        = 1'b1
    } state_e;

    // Per-pixel timing that travels alongside the memory read.
    typedef struct packed {
        logic origin;
        logic hbit;
        logic blank;
        logic vsync;
        logic hsync;
    } timing_t;

    localparam timing_t TIMING_RST = '{origin: 1'b0, hbit: 1'b0, blank: 1'b1,
                                       vsync: 1'b1, hsync: 1'b1};

    // Word offset of a line: v*320 as (v<<8)+(v<<6), no multiplier.
    function automatic logic [ADDR_W-1:0] line_offset(input logic [COORD_W-1:0] v);
        return (ADDR_W'(v) << 8) + (ADDR_W'(v) << 6);
    endfunction

endpackage

// File: rtl/frame_reader_sig_delay.sv
// Parameterised shift-register delay line with an asynchronous reset value.
module frame_reader_sig_delay #(
    parameter int unsigned       WIDTH   = 1,
    parameter int unsigned       DEPTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Shift one stage per clock.
    always_comb begin
        stage_d[0] = din;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers, cleared to the inactive value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_reader.sv
// Frame-buffer reader: fetches two-pixel words ahead of the raster and
// re-aligns pixels with the timing signals delayed by MEM_LAT+2 cycles.
module frame_reader
    import frame_reader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 19'd0,
    parameter int unsigned       MEM_LAT   = 2,
    parameter int unsigned       H_ACTIVE  = VGA_H_ACTIVE,
    parameter int unsigned       V_ACTIVE  = VGA_V_ACTIVE
) (
    input  logic               vclock,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               blank_in,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd,
    input  logic [WORD_W-1:0]  mem_rdata,
    output pixel_t             pixel,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               blank_out,
    output logic               frame_start
);

    // Timing bundle runs one stage short; the output registers add the last.
    localparam int unsigned PIPE = MEM_LAT + 2;
    localparam int unsigned TDEPTH = PIPE - 1;

    state_e              state_q, state_d;
    logic                mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   word_q, word_d;
    pixel_t              pixel_q, pixel_d;
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;
    logic                blank_q, blank_d;
    logic                frame_start_q, frame_start_d;

    logic                origin_c;
    logic                run_c;
    logic                fetch_c;
    logic                rvalid_c;
    timing_t             tin_c;
    timing_t             tdly;

    // Frame-origin detection and read gating: reads start on the origin cycle.
    always_comb begin
        state_d  = state_q;
        origin_c = (hcount == '0) && (vcount == '0);
        run_c    = (state_q == RUN) || origin_c;
        fetch_c  = run_c && (hcount < COORD_W'(H_ACTIVE)) &&
                   (vcount < COORD_W'(V_ACTIVE)) && !hcount[0];
        if (state_q == WAIT_FRAME && origin_c) begin
            state_d = RUN;
        end
    end

    // Timing signals to be delayed alongside the fetched word.
    always_comb begin
        tin_c        = TIMING_RST;
        tin_c.origin = origin_c && run_c;
        tin_c.hbit   = hcount[0];
        tin_c.blank  = blank_in;
        tin_c.vsync  = vsync_in;
        tin_c.hsync  = hsync_in;
    end

    frame_reader_sig_delay #(
        .WIDTH   ($bits(timing_t)),
        .DEPTH   (TDEPTH),
        .RST_VAL (TIMING_RST)
    ) u_timing_dly (
        .clk   (vclock),
        .rst_n (reset_n),
        .din   (tin_c),
        .dout  (tdly)
    );

    // Marks the cycle on which mem_rdata answers an issued strobe.
    frame_reader_sig_delay #(
        .WIDTH   (1),
        .DEPTH   (MEM_LAT),
        .RST_VAL (1'b0)
    ) u_rvalid_dly (
        .clk   (vclock),
        .rst_n (reset_n),
        .din   (mem_rd_q),
        .dout  (rvalid_c)
    );

    // Read request, word capture, pixel select and output alignment.
    always_comb begin
        mem_rd_d      = fetch_c;
        mem_addr_d    = mem_addr_q;
        if (fetch_c) begin
            mem_addr_d = BASE_ADDR + line_offset(vcount) + ADDR_W'(hcount[COORD_W-1:1]);
        end
        word_d        = rvalid_c ? mem_rdata : word_q;
        pixel_d       = '0;
        if (!tdly.blank && state_q == RUN) begin
            pixel_d = tdly.hbit ? word_d[23:12] : word_d[11:0];
        end
        hsync_d       = tdly.hsync;
        vsync_d       = tdly.vsync;
        blank_d       = tdly.blank;
        frame_start_d = tdly.origin;
    end

    // State and output registers.
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= WAIT_FRAME;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
            word_q        <= '0;
            pixel_q       <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_rd_q      <= mem_rd_d;
            mem_addr_q    <= mem_addr_d;
            word_q        <= word_d;
            pixel_q       <= pixel_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign pixel       = pixel_q;
    assign hsync_out   = hsync_q;
    assign vsync_out   = vsync_q;
    assign blank_out   = blank_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_frame_reader.sv
// Scoreboard bench for frame_reader: two instances (base 0 / latency 2 and
// base 0x7FFF0 / latency 3) share one raster of selected lines.
module tb_frame_reader;

    typedef struct packed {
        logic [31:0] due;
        logic [11:0] pix;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        fs;
    } exp_t;

    typedef struct packed {
        logic [31:0] due;
        logic [18:0] addr;
        logic [10:0] v;
    } rd_t;

    logic        vclock;
    logic        reset_n;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync_in;
    logic        vsync_in;
    logic        blank_in;

    logic [18:0] mem_addr  [2];
    logic        mem_rd    [2];
    logic [23:0] mem_rdata [2];
    logic [11:0] pixel     [2];
    logic        hs_o      [2];
    logic        vs_o      [2];
    logic        bl_o      [2];
    logic        fs_o      [2];
    logic [19:0] mpipe     [2][3];

    exp_t oq [2][$];
    rd_t  aq [2][$];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cycle_cnt = 0;
    logic [31:0] corner_due = '1;
    int          corner_hits = 0;
    int          fs_cnt [2] = '{0, 0};
    int          line0_reads [2] = '{0, 0};
    bit          model_run = 0;
    bit          push_en = 1;
    int          lines [8] = '{0, 1, 2, 100, 479, 480, 490, 523};

    initial vclock = 1'b0;
    always #5 vclock = ~vclock;

    always @(posedge vclock) cycle_cnt <= cycle_cnt + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 2 : 3;

        frame_reader #(
            .BASE_ADDR ((g == 0) ? 19'd0 : 19'h7FFF0),
            .MEM_LAT   (LAT),
            .H_ACTIVE  (640),
            .V_ACTIVE  (480)
        ) u_dut (
            .vclock      (vclock),
            .reset_n     (reset_n),
            .hcount      (hcount),
            .vcount      (vcount),
            .hsync_in    (hsync_in),
            .vsync_in    (vsync_in),
            .blank_in    (blank_in),
            .mem_addr    (mem_addr[g]),
            .mem_rd      (mem_rd[g]),
            .mem_rdata   (mem_rdata[g]),
            .pixel       (pixel[g]),
            .hsync_out   (hs_o[g]),
            .vsync_out   (vs_o[g]),
            .blank_out   (bl_o[g]),
            .frame_start (fs_o[g])
        );

        // Fixed-latency memory; not reset, so in-flight reads still return.
        always @(posedge vclock) begin
            mpipe[g][0] <= {mem_rd[g], mem_addr[g]};
            mpipe[g][1] <= mpipe[g][0];
            mpipe[g][2] <= mpipe[g][1];
        end

        assign mem_rdata[g] = mpipe[g][LAT-1][19] ?
            {12'(mpipe[g][LAT-1][18:0] + 19'd1), mpipe[g][LAT-1][11:0]} : 24'hA5A5A5;
    end

    function automatic int base_of(input int g);
        return (g == 0) ? 0 : 32'h7FFF0;
    endfunction

    function automatic int pipe_of(input int g);
        return (g == 0) ? 4 : 5;
    endfunction

    task automatic chk(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h",
                     name, g, cycle_cnt, act, exp);
        end
    endtask

    task automatic chk_reset_vals();
        for (int g = 0; g < 2; g++) begin
            chk("rst_mem_rd", g, 32'(mem_rd[g]), 32'd0);
            chk("rst_mem_addr", g, 32'(mem_addr[g]), 32'd0);
            chk("rst_pixel", g, 32'(pixel[g]), 32'd0);
            chk("rst_hsync", g, 32'(hs_o[g]), 32'd1);
            chk("rst_vsync", g, 32'(vs_o[g]), 32'd1);
            chk("rst_blank", g, 32'(bl_o[g]), 32'd1);
            chk("rst_frame_start", g, 32'(fs_o[g]), 32'd0);
        end
    endtask

    // Drive one raster cycle; rst=0 holds the DUTs in reset for that cycle.
    task automatic drive(input int h, input int v, input bit rst);
        exp_t e;
        rd_t  r;
        int   a;
        bit   origin;
        @(posedge vclock);
        #1;
        hcount   = 11'(h);
        vcount   = 11'(v);
        hsync_in = !(h >= 656 && h < 752);
        vsync_in = !(v == 490 || v == 491);
        blank_in = (h >= 640) || (v >= 480);
        if (!rst) begin
            reset_n   = 1'b0;
            model_run = 0;
            for (int g = 0; g < 2; g++) begin
                oq[g].delete();
                aq[g].delete();
            end
            #1;
            chk_reset_vals();
        end else begin
            reset_n = 1'b1;
            origin  = (h == 0) && (v == 0);
            if (origin) model_run = 1;
            if (model_run && v == 479 && h == 638) corner_due = cycle_cnt + 1;
            if (push_en) begin
                for (int g = 0; g < 2; g++) begin
                    a     = (base_of(g) + v * 320 + h / 2) % 524288;
                    e.due = cycle_cnt + 32'(pipe_of(g));
                    e.hs  = hsync_in;
                    e.vs  = vsync_in;
                    e.bl  = blank_in;
                    e.fs  = origin;
                    e.pix = (blank_in || !model_run) ? 12'h000 :
                            ((h % 2 == 0) ? 12'(a) : 12'(a + 1));
                    oq[g].push_back(e);
                    if (model_run && h < 640 && v < 480 && (h % 2 == 0)) begin
                        r.due  = cycle_cnt + 1;
                        r.addr = 19'(a);
                        r.v    = 11'(v);
                        aq[g].push_back(r);
                    end
                end
            end
        end
    endtask

    task automatic run_frame(input int first_line, input bit with_reset);
        for (int li = first_line; li < 8; li++) begin
            for (int h = 0; h < 800; h++) begin
                if (with_reset && lines[li] == 100 && h >= 300 && h < 303)
                    drive(h, lines[li], 0);
                else
                    drive(h, lines[li], 1);
            end
        end
    endtask

    // Output monitor: compares aligned outputs and read strobes as they appear.
    always @(negedge vclock) begin
        exp_t e;
        rd_t  r;
        if (reset_n === 1'b1) begin
            for (int g = 0; g < 2; g++) begin
                while (oq[g].size() > 0 && oq[g][0].due == cycle_cnt) begin
                    e = oq[g].pop_front();
                    chk("pixel", g, 32'(pixel[g]), 32'(e.pix));
                    chk("hsync_out", g, 32'(hs_o[g]), 32'(e.hs));
                    chk("vsync_out", g, 32'(vs_o[g]), 32'(e.vs));
                    chk("blank_out", g, 32'(bl_o[g]), 32'(e.bl));
                    chk("frame_start", g, 32'(fs_o[g]), 32'(e.fs));
                end
                if (bl_o[g]) chk("pixel_in_blank", g, 32'(pixel[g]), 32'd0);
                if (aq[g].size() > 0 && aq[g][0].due == cycle_cnt) begin
                    r = aq[g].pop_front();
                    chk("mem_rd", g, 32'(mem_rd[g]), 32'd1);
                    chk("mem_addr", g, 32'(mem_addr[g]), 32'(r.addr));
                    if (r.v == 0 && mem_rd[g]) line0_reads[g]++;
                end else begin
                    chk("no_read", g, 32'(mem_rd[g]), 32'd0);
                end
                if (fs_o[g]) fs_cnt[g]++;
            end
        end
    end

    // Hand-computed address at the last visible word of the frame.
    always @(negedge vclock) begin
        if (reset_n === 1'b1 && cycle_cnt == corner_due) begin
            chk("corner_addr", 0, 32'(mem_addr[0]), 32'h257FF);
            chk("corner_addr", 1, 32'(mem_addr[1]), 32'h257EF);
            corner_hits++;
        end
    end

    initial begin
        reset_n  = 1'b0;
        hcount   = 11'd0;
        vcount   = 11'd2;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        blank_in = 1'b0;
        for (int i = 0; i < 4; i++) drive(0, 2, 0);
        run_frame(2, 0);     // partial frame: no reads, blanked
        run_frame(0, 0);
        run_frame(0, 0);
        run_frame(0, 1);     // reset at line 100, pixel 300
        run_frame(0, 0);
        push_en = 0;
        for (int h = 0; h < 12; h++) drive(h, 480, 1);
        for (int g = 0; g < 2; g++) begin
            chk("out_queue_drained", g, 32'(oq[g].size()), 32'd0);
            chk("read_queue_drained", g, 32'(aq[g].size()), 32'd0);
            chk("frame_start_count", g, 32'(fs_cnt[g]), 32'd4);
            chk("line0_reads", g, 32'(line0_reads[g]), 32'd1280);
        end
        chk("corner_hits", 0, 32'(corner_hits), 32'd3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameters (name, default, meaning): BASE_ADDR, 19'd0, frame start word address; MEM_LAT, 2, fixed memory read latency in cycles; H_ACTIVE, 640, visible pixels/line; V_ACTIVE, 480, visible lines.
REQ-002 vclock  in  1  pixel clock; single clock domain.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 hcount  in  11  pixel number from timing generator.
REQ-005 vcount  in  11  line number from timing generator.
REQ-006 hsync_in, vsync_in  in  1 each  active-low syncs from timing generator.
REQ-007 blank_in  in  1  active-high blanking from timing generator.
REQ-008 mem_addr  out  19  word read address, registered.
REQ-009 mem_rd  out  1  read strobe, registered; one word per strobe.
REQ-010 mem_rdata  in  24  read data, valid exactly MEM_LAT cycles after mem_rd; [11:0] even pixel, [23:12] odd pixel.
REQ-011 pixel  out  12  RGB444 pixel aligned to delayed syncs.
REQ-012 hsync_out, vsync_out, blank_out  out  1 each  timing inputs delayed by PIPE.
REQ-013 frame_start  out  1  one-cycle pulse, aligned with first visible pixel of each frame on outputs.

Function
REQ-014 PIPE = MEM_LAT + 2 cycles; hsync_out/vsync_out/blank_out SHALL equal inputs delayed exactly PIPE cycles.
REQ-015 Fetch condition: hcount < H_ACTIVE, vcount < V_ACTIVE, hcount[0] == 0; on that cycle the next edge SHALL set mem_rd=1, mem_addr = BASE_ADDR + vcount*320 + hcount[10:1], mod 2^19; otherwise mem_rd=0, mem_addr holds.
REQ-016 vcount*320 SHALL be formed as (vcount<<8)+(vcount<<6); no multiplier.
REQ-017 Read data SHALL be captured into a word register on the cycle MEM_LAT after mem_rd (tracked by a MEM_LAT-deep valid shift register); held until next capture.
REQ-018 pixel SHALL select word[11:0] when the PIPE-delayed hcount[0]==0, word[23:12] when 1.
REQ-019 pixel SHALL be 12'h000 whenever blank output is 1 or state is WAIT_FRAME.
REQ-020 FSM states: WAIT_FRAME, RUN. WAIT_FRAME -> RUN on the cycle hcount==0 && vcount==0 is seen at input; RUN -> WAIT_FRAME only on reset.
REQ-021 In WAIT_FRAME no reads SHALL be issued even if fetch condition holds (partial first frame is blanked).
REQ-022 frame_start SHALL pulse PIPE cycles after input hcount==0 && vcount==0 while in RUN or on the transition into RUN.
REQ-023 hcount/vcount wrap (799->0, 523->0) SHALL need no special handling; fetch condition is purely combinational on inputs.
REQ-024 Address arithmetic overflow past 2^19-1 SHALL wrap silently.

Reset
REQ-025 On reset_n low, asynchronously: state=WAIT_FRAME, mem_rd=0, mem_addr=0, pixel=0, hsync_out=1, vsync_out=1, blank_out=1, frame_start=0, all delay and valid shift registers cleared to inactive (syncs 1, blank 1, valid 0).
REQ-026 Reset deasserted mid-frame SHALL resume in WAIT_FRAME; outputs blanked until next frame origin.
REQ-027 Read data arriving after reset for a pre-reset request SHALL be discarded (valid pipe cleared).

Structure
REQ-028 Shared package holds VGA geometry constants (H_ACTIVE, V_ACTIVE, words per line 320) and the 12-bit pixel type, shared with the timing generator.
REQ-029 One sub-module natural: sig_delay (parameterised width/depth shift register, async reset value parameter), used for sync/blank/hcount[0] and the read-valid pipe.

Verification
REQ-030 Reset, drive timing for one full frame, memory model returns addr[11:0]/addr+1 pattern -> no reads before first origin; outputs blanked; frame_start one pulse PIPE=4 cycles after origin.
REQ-031 Line 0, hcount 0..639, BASE_ADDR=0 -> 320 mem_rd strobes, addresses 0..319 on every other cycle; pixel sequence matches even/odd halves, 4 cycles late.
REQ-032 vcount=479, hcount=638 with BASE_ADDR=19'h7FFF0 -> mem_addr=(0x7FFF0+153599) mod 2^19 = 0x257EF.
REQ-033 Compare hsync_out/vsync_out/blank_out vs inputs over 2 frames -> exact 4-cycle delay, zero mismatches; pixel=0 whenever blank_out=1.
REQ-034 Assert reset_n low at vcount=100, hcount=300 for 3 cycles -> outputs reset values immediately; no reads and blank pixels until next (0,0); late returning data ignored.
REQ-035 MEM_LAT=3 build -> PIPE=5, all checks above hold with 5-cycle alignment.
